// File: rtl/jk_counter_pkg.sv
// Shared encodings for jk_counter and its per-bit jk_cell.
// Mode and JK command values line up so a single cell reads like the legacy JK flop.
package jk_counter_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flop with synchronous active-low reset.
// Latency: one cycle from jk to q. Backpressure: none.
module jk_cell
    import jk_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] jk,
    output logic       q,
    output logic       qb
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case (jk)
                JK_HOLD:  q <= q;
                JK_RESET: q <= 1'b0;
                JK_SET:   q <= 1'b1;
                default:  q <= ~q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_counter.sv
// Modulo up/down/load counter built from WIDTH jk_cell bits; sticky overflow under JK_COUNTER_OVF_STICKY_EN.
// Latency: one cycle from inputs to q/wrap/ovf; qb and tc are combinational. Backpressure: none, en gates counting.
module jk_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]        q_x;
    logic [WIDTH-1:0]      nxt;
    logic                  wrap_nxt;
    logic [WIDTH-1:0][1:0] jk;

    assign q_x = {1'b0, q};

    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP: begin
                    // An out-of-range q always wraps, even when saturating.
                    if (q_x >= TOP_X) begin
                        if (!(q_x == TOP_X && SATURATE != 0)) begin
                            nxt      = '0;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        nxt = WIDTH'(q_x + 1'b1);
                    end
                end
                MODE_DOWN: begin
                    if (q_x == '0) begin
                        if (SATURATE == 0) begin
                            nxt      = TOP;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        nxt = WIDTH'(q_x - 1'b1);
                    end
                end
                MODE_LOAD: nxt = ({1'b0, d} < MOD_X) ? d : TOP;
                default:   nxt = q;
            endcase
        end
    end

    always_comb begin
        jk = '0;
        for (int i = 0; i < WIDTH; i++) begin
            jk[i] = JK_HOLD;
            if (en) begin
                case (mode)
                    MODE_UP, MODE_DOWN: jk[i] = (nxt[i] != q[i]) ? JK_TOGGLE : JK_HOLD;
                    MODE_LOAD:          jk[i] = {nxt[i], ~nxt[i]};
                    default:            jk[i] = JK_HOLD;
                endcase
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .jk  (jk[g]),
            .q   (q[g]),
            .qb  (qb[g])
        );
    end

    assign tc = en & (((mode == MODE_UP) & (q == TOP)) | ((mode == MODE_DOWN) & (q == '0)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

`ifdef JK_COUNTER_OVF_STICKY_EN
    logic ovf_r;
    logic load_edge;
    logic sat_hit;

    assign load_edge = en & (mode == MODE_LOAD);
    // tc at a range end with saturation on is exactly a blocked count attempt.
    assign sat_hit   = tc & (SATURATE != 0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (load_edge) begin
            ovf_r <= 1'b0;
        end else if (wrap_nxt | sat_hit) begin
            ovf_r <= 1'b1;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/jk_counter.md
Name: jk_counter

Overview:
- Parametrised synchronous up/down/load counter built from WIDTH JK cells; next generation of the team's single-bit JK flip-flop.
- Keeps the 2-bit mode encoding of the JK cell (hold/reset-like/set-like/toggle), generalised to WIDTH bits with a programmable modulus, optional saturation, terminal-count and wrap indication.
- Used as the shared counter primitive for timers and dividers.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 16, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends; 1 = stick at range ends.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- en  input  1  count enable; when 0 the counter holds regardless of mode.
- mode  input  2  00 HOLD, 01 DOWN, 10 UP, 11 LOAD.
- d  input  WIDTH  load value, used in LOAD only.
- q  output  WIDTH  counter value.
- qb  output  WIDTH  bitwise ~q, combinational.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse marking a wrap.
- ovf  output  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset: rst==0 at a rising clk gives q=0, wrap=0, ovf=0 next cycle. Reset has priority over en and mode, including mid-count and mid-load.
- All state updates on rising clk. Latency from inputs to q/wrap is one cycle.
- en==0 or mode==HOLD: q holds and wrap is 0 next cycle.
- UP:
  - q<MODULUS-1: q+1.
  - q==MODULUS-1 with SATURATE=0: q becomes 0 and wrap=1 next cycle.
  - q==MODULUS-1 with SATURATE=1: q holds and wrap=0.
- DOWN:
  - q>0: q-1.
  - q==0 with SATURATE=0: q becomes MODULUS-1 and wrap=1.
  - q==0 with SATURATE=1: q holds and wrap=0.
- LOAD: q=d if d<MODULUS, otherwise q=MODULUS-1 (clamp). wrap=0.
- tc = en & ((mode==UP & q==MODULUS-1) | (mode==DOWN & q==0)). This holds for both SATURATE settings.
- wrap is registered: high for exactly the one cycle after a wrapping edge. Consecutive wraps (MODULUS=2, UP held) give wrap high on every such cycle.
- Cell drive, per bit i, with n = next value:
  - UP/DOWN: jk_i = 11 when n_i != q_i, else 00.
  - LOAD: jk_i = {n_i, ~n_i}.
  - HOLD or en==0: jk_i = 00.
- Arithmetic is performed WIDTH+1 bits wide internally. No X propagation from d outside LOAD.
- If q is ever >= MODULUS, the next UP goes to 0 (treated as wrap); DOWN decrements normally.

Optional Feature:
- Macro: JK_COUNTER_OVF_STICKY_EN.
- Enabled:
  - ovf sets on the same edge that asserts wrap, and also on a saturating UP/DOWN attempt at a range end.
  - ovf stays set until rst==0 or a LOAD edge.
  - If set and clear occur on the same edge, the LOAD clear wins.
- Disabled: ovf is tied to 0 and no flop is inferred. The port remains present so the bench is shared.

Decomposition:
- Package jk_counter_pkg:
  - mode localparams MODE_HOLD=2'b00, MODE_DOWN=2'b01, MODE_UP=2'b10, MODE_LOAD=2'b11.
  - JK command constants JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11.
- One sub-module jk_cell: 1-bit JK flop with synchronous active-low rst, jk[1:0] input, q/qb outputs; instantiated WIDTH times via generate.
- Next-value, clamp, tc, wrap and ovf logic live in jk_counter.

Test Plan:
- Reset: WIDTH=4, MODULUS=10, drive mode=UP, en=1 for 5 cycles, then rst=0 for 1 cycle -> q=0, wrap=0, ovf=0, qb=4'hF next cycle.
- Wrap up: MODULUS=10, SATURATE=0, LOAD d=8, then UP for 3 cycles -> q sequence 9, 0, 1. tc=1 while q=9. wrap=1 only in the cycle q=0.
- Wrap down: LOAD d=1, then DOWN for 3 cycles -> q sequence 0, 9, 8. wrap pulses once. With JK_COUNTER_OVF_STICKY_EN, ovf=1 and stays set until the next LOAD.
- Saturate: SATURATE=1, MODULUS=10, LOAD d=9, then UP for 4 cycles -> q stays 9, wrap stays 0, tc=1. With the macro, ovf=1.
- Load clamp and enable: LOAD d=4'hF (MODULUS=10) -> q=9. Then en=0 with UP for 3 cycles -> q stays 9 and tc=0.
- Full range: WIDTH=4, MODULUS=16, UP for 32 cycles from 0 -> q follows 0..15,0..15 with wrap pulsed twice. Check qb==~q every cycle.
